// File: rtl/charge_injection_sequencer_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | charge_injection_sequencer_if : control/config/output bundle          |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
interface charge_injection_sequencer_if;
  logic       enable;
  logic       trigger;
  logic       abort;
  logic [7:0] injCount;
  logic [7:0] gap;
  logic [4:0] delayStart;
  logic [4:0] delayStep;
  logic       chargeInjectionCmd;
  logic [4:0] delay;
  logic       busy;
  logic       done;
  logic [7:0] injIndex;

  modport master (
    output enable, trigger, abort, injCount, gap, delayStart, delayStep,
    input  chargeInjectionCmd, delay, busy, done, injIndex
  );

  modport slave (
    input  enable, trigger, abort, injCount, gap, delayStart, delayStep,
    output chargeInjectionCmd, delay, busy, done, injIndex
  );
endinterface
`default_nettype wire

// File: rtl/charge_injection_sequencer.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | charge_injection_sequencer : trigger -> burst of spaced inject cmds   |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module charge_injection_sequencer #(
  parameter int CMD_WIDTH = 2,
  parameter int MIN_GAP   = 6
) (
  input  logic                          clk40,
  input  logic                          reset,
  charge_injection_sequencer_if.slave   bus
);

  localparam logic [7:0] C_CMD_LAST = 8'(CMD_WIDTH - 1);
  localparam logic [7:0] C_MIN_GAP  = 8'(MIN_GAP);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ASSERT = 2'd1,
    GAP    = 2'd2
  } state_t;

  state_t     r_state, n_state;
  logic       r_cmd, n_cmd;
  logic [4:0] r_delay, n_delay;
  logic       r_busy, n_busy;
  logic       r_done, n_done;
  logic [7:0] r_idx, n_idx;
  logic [7:0] r_cnt, n_cnt;
  logic [7:0] r_count, n_count;
  logic [7:0] r_geff, n_geff;
  logic [4:0] r_step, n_step;
  logic [7:0] w_geff_in;
  logic       w_start;
  logic       w_stop;

  assign w_geff_in = (bus.gap < C_MIN_GAP) ? C_MIN_GAP : bus.gap;
  assign w_start   = bus.trigger && bus.enable && !bus.abort && (bus.injCount != 8'd0);
  assign w_stop    = bus.abort || !bus.enable;

  always_ff @(posedge clk40 or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cmd   <= 1'b0;
      r_delay <= 5'd0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_idx   <= 8'd0;
      r_cnt   <= 8'd0;
      r_count <= 8'd0;
      r_geff  <= 8'd0;
      r_step  <= 5'd0;
    end else begin
      r_state <= n_state;
      r_cmd   <= n_cmd;
      r_delay <= n_delay;
      r_busy  <= n_busy;
      r_done  <= n_done;
      r_idx   <= n_idx;
      r_cnt   <= n_cnt;
      r_count <= n_count;
      r_geff  <= n_geff;
      r_step  <= n_step;
    end
  end

  always_comb begin
    n_state = r_state;
    n_cmd   = r_cmd;
    n_delay = r_delay;
    n_busy  = r_busy;
    n_done  = 1'b0;
    n_idx   = r_idx;
    n_cnt   = r_cnt;
    n_count = r_count;
    n_geff  = r_geff;
    n_step  = r_step;
    case (r_state)
      IDLE: begin
        if (w_start) begin
          n_state = ASSERT;
          n_count = bus.injCount;
          n_geff  = w_geff_in;
          n_step  = bus.delayStep;
          n_delay = bus.delayStart;
          n_cmd   = 1'b1;
          n_busy  = 1'b1;
          n_idx   = 8'd0;
          n_cnt   = 8'd0;
        end
      end
      ASSERT, GAP: begin
        if (w_stop) begin
          // delay and injIndex deliberately hold so software can see where it stopped
          n_state = IDLE;
          n_cmd   = 1'b0;
          n_busy  = 1'b0;
        end else begin
          n_cnt = r_cnt + 8'd1;
          if (r_state == ASSERT) begin
            if (r_cnt == C_CMD_LAST) begin
              n_state = GAP;
              n_cmd   = 1'b0;
            end
          end else if (r_cnt == r_geff - 8'd1) begin
            if (r_idx < r_count - 8'd1) begin
              n_state = ASSERT;
              n_cmd   = 1'b1;
              n_idx   = r_idx + 8'd1;
              n_delay = r_delay + r_step;
              n_cnt   = 8'd0;
            end else begin
              n_state = IDLE;
              n_busy  = 1'b0;
              n_done  = 1'b1;
            end
          end
        end
      end
      default: n_state = IDLE;
    endcase
  end

  assign bus.chargeInjectionCmd = r_cmd;
  assign bus.delay              = r_delay;
  assign bus.busy               = r_busy;
  assign bus.done               = r_done;
  assign bus.injIndex           = r_idx;

endmodule
`default_nettype wire

// File: tb/tb_charge_injection_sequencer.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_charge_injection_sequencer : scoreboard bench, directed + random   |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module tb_charge_injection_sequencer;

  localparam int CW = 2;
  localparam int MG = 6;
  localparam int EV_RISE = 0;
  localparam int EV_FALL = 1;
  localparam int EV_DONE = 2;

  typedef struct {
    int         cyc;
    int         kind;
    logic [4:0] dly;
    logic [7:0] idx;
  } ev_t;

  logic clk40 = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  ev_t  sb[$];
  int   cur_start = 0, cur_end = 0, cur_g = 6, cur_ds = 0, cur_st = 0;
  logic       prev_cmd = 1'b0;
  logic [4:0] exp_dly = 5'd0;
  logic [7:0] exp_idx = 8'd0;

  charge_injection_sequencer_if bus();

  charge_injection_sequencer #(.CMD_WIDTH(CW), .MIN_GAP(MG)) dut (
    .clk40 (clk40),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk40 = ~clk40;
  always @(posedge clk40) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s @edge %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic check_ev(input int kind);
    ev_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_event @edge %0d: kind %0d with empty scoreboard", cyc, kind);
    end else begin
      e = sb.pop_front();
      chk("ev_kind", kind, e.kind);
      chk("ev_cycle", cyc, e.cyc);
      chk("ev_delay", int'(bus.delay), int'(e.dly));
      chk("ev_index", int'(bus.injIndex), int'(e.idx));
      exp_dly = e.dly;
      exp_idx = e.idx;
    end
  endtask

  // Monitor: samples on the falling edge, away from the active edge
  always @(negedge clk40) begin
    if (!reset) begin
      prev_cmd = bus.chargeInjectionCmd;
      exp_dly  = 5'd0;
      exp_idx  = 8'd0;
    end else begin
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL missed_event @edge %0d: kind %0d expected at edge %0d", cyc, sb[0].kind, sb[0].cyc);
        void'(sb.pop_front());
      end
      if (bus.chargeInjectionCmd && !prev_cmd) check_ev(EV_RISE);
      if (!bus.chargeInjectionCmd && prev_cmd) check_ev(EV_FALL);
      if (bus.done) check_ev(EV_DONE);
      chk("busy", int'(bus.busy), int'(cyc >= cur_start && cyc < cur_end));
      chk("delay_level", int'(bus.delay), int'(exp_dly));
      chk("index_level", int'(bus.injIndex), int'(exp_idx));
      prev_cmd = bus.chargeInjectionCmd;
    end
  end

  // One clock of stimulus; the reference model predicts what the edge does
  task automatic step(input bit trig, input bit abt, input bit en, input bit rnd);
    int  e, t, k, g, n;
    ev_t ev;
    @(negedge clk40);
    #1;
    if (rnd) begin
      bus.injCount   = 8'($urandom_range(0, 5));
      bus.gap        = 8'($urandom_range(0, 12));
      bus.delayStart = 5'($urandom);
      bus.delayStep  = 5'($urandom);
    end
    bus.trigger = trig;
    bus.abort   = abt;
    bus.enable  = en;
    e = cyc + 1;
    if ((abt || !en) && e > cur_start && e <= cur_end) begin
      t = e - 1;
      k = (t - cur_start) / cur_g;
      while (sb.size() > 0 && sb[$].cyc >= e) void'(sb.pop_back());
      if ((t - cur_start) % cur_g < CW) begin
        ev.cyc = e; ev.kind = EV_FALL;
        ev.dly = 5'((cur_ds + k * cur_st) % 32); ev.idx = 8'(k);
        sb.push_back(ev);
      end
      cur_end = e;
    end else if (trig && en && !abt && bus.injCount != 8'd0 && e > cur_end) begin
      g = (int'(bus.gap) < MG) ? MG : int'(bus.gap);
      n = int'(bus.injCount);
      cur_g = g; cur_ds = int'(bus.delayStart); cur_st = int'(bus.delayStep);
      for (int i = 0; i < n; i++) begin
        ev.dly = 5'((cur_ds + i * cur_st) % 32); ev.idx = 8'(i);
        ev.cyc = e + i * g;      ev.kind = EV_RISE; sb.push_back(ev);
        ev.cyc = e + i * g + CW; ev.kind = EV_FALL; sb.push_back(ev);
      end
      ev.cyc = e + n * g; ev.kind = EV_DONE;
      ev.dly = 5'((cur_ds + (n - 1) * cur_st) % 32); ev.idx = 8'(n - 1);
      sb.push_back(ev);
      cur_start = e;
      cur_end   = e + n * g;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic cfg(input int n, input int g, input int ds, input int st);
    bus.injCount = 8'(n); bus.gap = 8'(g); bus.delayStart = 5'(ds); bus.delayStep = 5'(st);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_cmd"},   int'(bus.chargeInjectionCmd), 0);
    chk({tag, "_delay"}, int'(bus.delay), 0);
    chk({tag, "_busy"},  int'(bus.busy), 0);
    chk({tag, "_done"},  int'(bus.done), 0);
    chk({tag, "_index"}, int'(bus.injIndex), 0);
  endtask

  initial begin
    int len, g;
    bus.enable = 1'b1; bus.trigger = 1'b0; bus.abort = 1'b0;
    cfg(0, 0, 0, 0);
    #1 reset = 1'b0;
    repeat (3) @(posedge clk40);
    #2 chk_zero("reset");
    @(negedge clk40);
    #1 reset = 1'b1;
    idle(2);

    cfg(1, 10, 7, 0);   step(1, 0, 1, 0); idle(14);
    cfg(4, 8, 30, 1);   step(1, 0, 1, 0); idle(36);
    cfg(3, 2, 5, 3);    step(1, 0, 1, 0); idle(22);
    cfg(0, 8, 9, 1);    step(1, 0, 1, 0); idle(5);

    // retrigger mid-burst and on the done edge are dropped; one cycle later starts
    cfg(2, 6, 12, 2);   step(1, 0, 1, 0);
    idle(2); step(1, 0, 1, 0); idle(8);
    step(1, 0, 1, 0); step(1, 0, 1, 0); idle(16);

    cfg(5, 8, 3, 4);    step(1, 0, 1, 0); idle(11);
    step(0, 1, 1, 0); idle(4);
    chk("abort_index", int'(bus.injIndex), 1);
    chk("abort_busy", int'(bus.busy), 0);
    idle(40);

    cfg(3, 7, 20, 5);   step(1, 0, 1, 0); step(0, 0, 0, 0); idle(25);

    cfg(3, 8, 9, 1);    step(1, 0, 1, 0);
    @(posedge clk40);
    #2;
    bus.trigger = 1'b0;
    reset = 1'b0;
    sb.delete();
    cur_start = 0; cur_end = 0;
    #1 chk_zero("async_reset");
    @(negedge clk40);
    #1 reset = 1'b1;
    idle(2);
    cfg(2, 9, 17, 3);   step(1, 0, 1, 0); idle(22);

    for (int it = 0; it < 30; it++) begin
      step(1, 0, 1, 1);
      g   = (int'(bus.gap) < MG) ? MG : int'(bus.gap);
      len = int'(bus.injCount) * g + int'($urandom_range(1, 6));
      for (int c = 0; c < len; c++)
        step($urandom_range(0, 7) == 0, $urandom_range(0, 39) == 0,
             $urandom_range(0, 59) != 0, 1'b1);
    end
    idle(70);
    chk("scoreboard_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
